uart_baud_gen: RTL and testbench

//  Parametrised, runtime-programmable baud tick generator for the UART TX/RX paths.
//  A fractional-N divider produces a 1-cycle oversample tick (os_tick) and a bit tick (bit_tick).
//  It also drives a legacy 50%-duty baud_clk. Sits between the system clock and uart_tx/uart_rx.
//  RX re-aligns the bit phase on start-bit detection via restart.

---
 rtl/uart_baud_gen_pkg.sv | 29 ++
 rtl/uart_baud_gen_frac_div.sv | 96 +++++++++
 rtl/uart_baud_gen.sv | 70 +++++++
 tb/tb_uart_baud_gen.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_baud_gen_pkg.sv
// Shared UART timing definitions: oversample/fraction defaults and the
// helpers used to size the phase counter and derive the reset divisor.
package uart_baud_gen_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_FRAC_W     = 4;

    // Ceiling log2, minimum result 0 (used for port and counter widths).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Default divisor in units of 1/2^frac_w clocks per oversample period,
    // rounded to nearest: round(clk_freq * 2^frac_w / (baud * oversample)).
    function automatic int def_div(input int clk_freq, input int baud,
                                   input int oversample, input int frac_w);
        longint num;
        longint den;
        num = longint'(clk_freq) << frac_w;
        den = longint'(baud) * longint'(oversample);
        return int'((num + den / 2) / den);
    endfunction

endpackage

// File: rtl/uart_baud_gen_frac_div.sv
// Fractional-N period divider: a down-counter whose reload length is the
// integer divisor plus the carry of a fractional accumulator. Divisor
// updates land in a shadow register and reach the active copy only at a
// period boundary (or immediately while the generator is idle).
module uart_baud_gen_frac_div #(
    parameter int DIV_W   = 16,
    parameter int FRAC_W  = 4,
    parameter int DEF_DIV = 5208
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              div_load,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              per_done
);

    localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(DEF_DIV >> FRAC_W);
    localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEF_DIV);
    localparam logic [DIV_W:0]    MIN_LEN  = (DIV_W+1)'(2);

    logic              start_p0;
    logic [DIV_W-1:0]  cnt_p0;
    logic [FRAC_W-1:0] acc_p0;
    logic [DIV_W-1:0]  act_int_p0;
    logic [FRAC_W-1:0] act_frac_p0;
    logic [DIV_W-1:0]  shd_int_p0;
    logic [FRAC_W-1:0] shd_frac_p0;

    logic [DIV_W-1:0]  shd_int_nx;
    logic [FRAC_W-1:0] shd_frac_nx;
    logic [FRAC_W:0]   sum_next;
    logic [DIV_W:0]    start_len;
    logic [DIV_W:0]    next_len;
    logic [DIV_W-1:0]  start_cnt;
    logic [DIV_W-1:0]  next_cnt;

    // Period length with the integer part saturated up to 2 clocks.
    function automatic logic [DIV_W:0] period_len(input logic [DIV_W-1:0] d_int,
                                                  input logic             carry);
        logic [DIV_W:0] base;
        base = ({1'b0, d_int} < MIN_LEN) ? MIN_LEN : {1'b0, d_int};
        return base + {{DIV_W{1'b0}}, carry};
    endfunction

    // A load in the same cycle as a copy is passed straight through.
    assign shd_int_nx  = div_load ? div_int  : shd_int_p0;
    assign shd_frac_nx = div_load ? div_frac : shd_frac_p0;

    // First period starts from a cleared accumulator, so it never carries;
    // the start edge already counts as its first cycle, hence length-2.
    assign start_len = period_len(act_int_p0, 1'b0);
    assign start_cnt = DIV_W'(start_len - MIN_LEN);

    assign sum_next  = {1'b0, acc_p0} + {1'b0, shd_frac_nx};
    assign next_len  = period_len(shd_int_nx, sum_next[FRAC_W]);
    assign next_cnt  = DIV_W'(next_len - {{DIV_W{1'b0}}, 1'b1});

    assign per_done  = run && !start_p0 && (cnt_p0 == '0);

    // Counter, accumulator and shadow/active divisor update.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_p0    <= 1'b1;
            cnt_p0      <= '0;
            acc_p0      <= '0;
            act_int_p0  <= DEF_INT;
            act_frac_p0 <= DEF_FRAC;
            shd_int_p0  <= DEF_INT;
            shd_frac_p0 <= DEF_FRAC;
        end else begin
            shd_int_p0  <= shd_int_nx;
            shd_frac_p0 <= shd_frac_nx;
            if (!run) begin
                start_p0    <= 1'b1;
                cnt_p0      <= '0;
                acc_p0      <= '0;
                act_int_p0  <= shd_int_nx;
                act_frac_p0 <= shd_frac_nx;
            end else if (start_p0) begin
                start_p0 <= 1'b0;
                cnt_p0   <= start_cnt;
                acc_p0   <= act_frac_p0;
            end else if (cnt_p0 == '0) begin
                act_int_p0  <= shd_int_nx;
                act_frac_p0 <= shd_frac_nx;
                cnt_p0      <= next_cnt;
                acc_p0      <= sum_next[FRAC_W-1:0];
            end else begin
                cnt_p0 <= cnt_p0 - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// Baud tick generator: fractional divider feeding the oversample phase
// counter, with registered os_tick, bit_tick and 50%-duty baud_clk.
module uart_baud_gen
    import uart_baud_gen_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int DEFAULT_BAUD = 9600,
    parameter int OVERSAMPLE   = UART_OVERSAMPLE,
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = UART_FRAC_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic                           restart,
    input  logic                           div_load,
    input  logic [DIV_W-1:0]               div_int,
    input  logic [FRAC_W-1:0]              div_frac,
    output logic                           os_tick,
    output logic                           bit_tick,
    output logic                           baud_clk,
    output logic [clog2(OVERSAMPLE)-1:0]   os_phase
);

    localparam int               DEF_DIV = def_div(CLK_FREQ, DEFAULT_BAUD, OVERSAMPLE, FRAC_W);
    localparam int               OS_W    = clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_HALF = OS_W'(OVERSAMPLE / 2);

    logic            run;
    logic            per_done;
    logic [OS_W-1:0] phase_nx;

    // restart forces the start state exactly like a disabled cycle
    assign run      = enable && !restart;
    assign phase_nx = os_phase + 1'b1;

    uart_baud_gen_frac_div #(
        .DIV_W   (DIV_W),
        .FRAC_W  (FRAC_W),
        .DEF_DIV (DEF_DIV)
    ) u_frac_div (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .div_load (div_load),
        .div_int  (div_int),
        .div_frac (div_frac),
        .per_done (per_done)
    );

    // Phase counter and output registers; idle state matches reset.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            os_tick  <= 1'b0;
            bit_tick <= 1'b0;
            baud_clk <= 1'b1;
            os_phase <= '0;
        end else if (per_done) begin
            os_tick  <= 1'b1;
            bit_tick <= (os_phase == OS_LAST);
            os_phase <= phase_nx;
            baud_clk <= (phase_nx < OS_HALF);
        end else begin
            os_tick  <= 1'b0;
            bit_tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen: directed scenarios plus randomized control,
// compared cycle by cycle against a deadline-based reference model.
module tb_uart_baud_gen;

    localparam int OS     = 4;
    localparam int DIV_W  = 8;
    localparam int FRAC_W = 4;
    localparam int FSCALE = 1 << FRAC_W;
    localparam int CLK_A  = 1_000_000;
    localparam int BAUD_A = 50_000;
    localparam int CLK_B  = 2_000_000;
    localparam int BAUD_B = 57_600;
    localparam int DEF_A  = int'((longint'(CLK_A) * FSCALE + longint'(BAUD_A) * OS / 2) / (longint'(BAUD_A) * OS));
    localparam int DEF_B  = int'((longint'(CLK_B) * FSCALE + longint'(BAUD_B) * OS / 2) / (longint'(BAUD_B) * OS));

    logic              clk;
    logic              rst, enable, restart, div_load;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              os_tick, bit_tick, baud_clk;
    logic [1:0]        os_phase;

    logic              rst_b, enable_b, restart_b, div_load_b;
    logic [DIV_W-1:0]  div_int_b;
    logic [FRAC_W-1:0] div_frac_b;
    logic              os_tick_b, bit_tick_b, baud_clk_b;
    logic [1:0]        os_phase_b;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int edge_no = 0;
    bit m_run;
    int m_next, m_act_i, m_act_f, m_shd_i, m_shd_f, m_acc, m_phase;
    bit exp_os, exp_bit, exp_baud;

    int tq[$];
    int bq[$];
    int e0, r, t_prev, ld, cyc, nb, t_first, t_last;
    bit found;
    longint err, tol;

    uart_baud_gen #(
        .CLK_FREQ(CLK_A), .DEFAULT_BAUD(BAUD_A), .OVERSAMPLE(OS),
        .DIV_W(DIV_W), .FRAC_W(FRAC_W)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .restart(restart),
        .div_load(div_load), .div_int(div_int), .div_frac(div_frac),
        .os_tick(os_tick), .bit_tick(bit_tick), .baud_clk(baud_clk),
        .os_phase(os_phase)
    );

    uart_baud_gen #(
        .CLK_FREQ(CLK_B), .DEFAULT_BAUD(BAUD_B), .OVERSAMPLE(OS),
        .DIV_W(DIV_W), .FRAC_W(FRAC_W)
    ) dut_b (
        .clk(clk), .rst(rst_b), .enable(enable_b), .restart(restart_b),
        .div_load(div_load_b), .div_int(div_int_b), .div_frac(div_frac_b),
        .os_tick(os_tick_b), .bit_tick(bit_tick_b), .baud_clk(baud_clk_b),
        .os_phase(os_phase_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic signed [63:0] got,
                            input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Length of the period now starting; consumes one accumulator step.
    function automatic int new_period();
        int i;
        int s;
        i = (m_act_i < 2) ? 2 : m_act_i;
        s = m_acc + m_act_f;
        m_acc = s % FSCALE;
        return i + s / FSCALE;
    endfunction

    // Advance the model by one clock edge using the inputs applied to it.
    task automatic model_edge();
        int sh_i, sh_f, p;
        edge_no++;
        sh_i = div_load ? int'(div_int) : m_shd_i;
        sh_f = div_load ? int'(div_frac) : m_shd_f;
        exp_os = 0;
        exp_bit = 0;
        if (rst) begin
            m_run = 0; m_acc = 0; m_phase = 0;
            m_act_i = DEF_A / FSCALE; m_act_f = DEF_A % FSCALE;
            m_shd_i = m_act_i;        m_shd_f = m_act_f;
        end else begin
            m_shd_i = sh_i; m_shd_f = sh_f;
            if (!enable || restart) begin
                m_run = 0; m_acc = 0; m_phase = 0;
                m_act_i = sh_i; m_act_f = sh_f;
            end else if (!m_run) begin
                m_run = 1;
                p = new_period();
                m_next = edge_no + p - 1;
            end else if (edge_no == m_next) begin
                m_act_i = sh_i; m_act_f = sh_f;
                p = new_period();
                m_next = edge_no + p;
                exp_os = 1;
                exp_bit = (m_phase == OS - 1);
                m_phase = (m_phase + 1) % OS;
            end
        end
        exp_baud = (m_phase < OS / 2);
    endtask

    task automatic tick_cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_eq("os_tick", os_tick, exp_os);
        check_eq("bit_tick", bit_tick, exp_bit);
        check_eq("baud_clk", baud_clk, exp_baud);
        check_eq("os_phase", os_phase, m_phase);
        if (os_tick) tq.push_back(edge_no);
        if (bit_tick) bq.push_back(edge_no);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) tick_cycle();
    endtask

    task automatic idle_load(input int di, input int df);
        enable = 0; div_load = 1; div_int = DIV_W'(di); div_frac = FRAC_W'(df);
        tick_cycle();
        div_load = 0; enable = 1;
        tq.delete(); bq.delete();
        e0 = edge_no + 1;
    endtask

    initial begin
        rst = 1; enable = 0; restart = 0; div_load = 0; div_int = '0; div_frac = '0;
        rst_b = 1; enable_b = 0; restart_b = 0; div_load_b = 0; div_int_b = '0; div_frac_b = '0;

        // reset held 3 cycles
        for (int i = 0; i < 3; i++) begin
            tick_cycle();
            check_eq("rst_os_tick", os_tick, 0);
            check_eq("rst_bit_tick", bit_tick, 0);
            check_eq("rst_baud_clk", baud_clk, 1);
            check_eq("rst_os_phase", os_phase, 0);
        end
        check_eq("rst_b_os_tick", os_tick_b, 0);
        check_eq("rst_b_bit_tick", bit_tick_b, 0);
        check_eq("rst_b_baud_clk", baud_clk_b, 1);
        check_eq("rst_b_os_phase", os_phase_b, 0);
        rst = 0;

        // integer divide by 4
        idle_load(4, 0);
        run_cycles(70);
        check_eq("div4_count", tq.size(), 17);
        check_eq("div4_latency", tq[0] - e0, 3);
        check_eq("div4_int1", tq[1] - tq[0], 4);
        check_eq("div4_int2", tq[2] - tq[1], 4);
        check_eq("div4_bits", bq.size(), 4);
        check_eq("div4_bit_int", bq[1] - bq[0], 16);

        // fractional 4.5
        idle_load(4, 8);
        run_cycles(80);
        check_eq("frac_count", tq.size(), 17);
        check_eq("frac_latency", tq[0] - e0, 3);
        check_eq("frac_int1", tq[1] - tq[0], 5);
        check_eq("frac_int2", tq[2] - tq[1], 4);
        check_eq("frac_16_periods", tq[16] - tq[0], 72);

        // clamp of divisor 1 to 2
        idle_load(1, 0);
        run_cycles(20);
        check_eq("clamp_count", tq.size(), 10);
        check_eq("clamp_latency", tq[0] - e0, 1);
        check_eq("clamp_int", tq[1] - tq[0], 2);

        // load during a period applies from the next period
        idle_load(4, 0);
        run_cycles(8);
        t_prev = tq[tq.size() - 1];
        div_load = 1; div_int = 8'd6; div_frac = 4'd0;
        tick_cycle();
        div_load = 0;
        ld = edge_no;
        tq.delete();
        run_cycles(20);
        check_eq("load_cur_period", tq[0] - t_prev, 4);
        check_eq("load_cur_vs_load", tq[0] - ld, 3);
        check_eq("load_next_period", tq[1] - tq[0], 6);
        check_eq("load_count", tq.size(), 3);

        // restart coinciding with a tick at os_phase 2
        div_load = 1; div_int = 8'd4; div_frac = 4'd0;
        tick_cycle();
        div_load = 0;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (os_phase == 2 && m_run && (edge_no + 1 == m_next)) begin
                found = 1;
                break;
            end
            tick_cycle();
        end
        check_eq("restart_found", found, 1);
        restart = 1;
        tick_cycle();
        restart = 0;
        r = edge_no;
        check_eq("restart_no_tick", os_tick, 0);
        check_eq("restart_no_bit", bit_tick, 0);
        check_eq("restart_phase", os_phase, 0);
        tq.delete();
        run_cycles(6);
        check_eq("restart_count", tq.size(), 1);
        check_eq("restart_latency", tq[0] - r, 4);
        enable = 0;
        tick_cycle();
        check_eq("disable_os_tick", os_tick, 0);
        check_eq("disable_baud_clk", baud_clk, 1);
        check_eq("disable_phase", os_phase, 0);

        // randomized control and divisor traffic
        enable = 1;
        for (int i = 0; i < 2000; i++) begin
            rst      = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) enable = !enable;
            restart  = ($urandom_range(0, 59) == 0);
            div_load = ($urandom_range(0, 29) == 0);
            div_int  = DIV_W'($urandom_range(0, 9));
            div_frac = FRAC_W'($urandom_range(0, 15));
            tick_cycle();
        end
        rst = 0; enable = 0; restart = 0; div_load = 0;

        // long-run bit rate of the default divisor
        rst_b = 0; enable_b = 1;
        nb = 0; cyc = 0; t_first = 0; t_last = 0;
        while (nb < 1001 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (bit_tick_b) begin
                if (nb == 0) t_first = cyc;
                t_last = cyc;
                nb++;
            end
        end
        check_eq("mean_bits_seen", nb, 1001);
        check_eq("mean_cycles", t_last - t_first, 1000 * OS * DEF_B / FSCALE);
        err = longint'(t_last - t_first) * BAUD_B - longint'(1000) * CLK_B;
        if (err < 0) err = -err;
        tol = longint'(CLK_B);
        check_eq("mean_within_0p1pct", (err * 1000 <= tol * 1000) ? 1 : 0, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
